// File: rtl/byte_ram_ctrl_pkg.sv
// Shared definitions for the byte RAM controller: RAM geometry, command
// encodings and FSM state encodings.
package byte_ram_ctrl_pkg;

    localparam int BYTE_RAM_LEN      = 8;
    localparam int BYTE_RAM_ADDR_LEN = 7;

    typedef enum logic [1:0] {
        CMD_READ    = 2'd0,
        CMD_WRITE   = 2'd1,
        CMD_BIT_SET = 2'd2,
        CMD_BIT_CLR = 2'd3
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ISSUE = 3'd1,
        ST_RD_CAP   = 3'd2,
        ST_WR       = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

endpackage

// File: rtl/byte_ram_ctrl.sv
// Two-port byte RAM controller: fixed-priority arbitration (A over B), read,
// write and read-modify-write bit set/clear against a registered-output RAM.
module byte_ram_ctrl
    import byte_ram_ctrl_pkg::*;
#(
    parameter int DATA_W = BYTE_RAM_LEN,
    parameter int ADDR_W = BYTE_RAM_ADDR_LEN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              aReq,
    input  logic [1:0]        aCmd,
    input  logic [ADDR_W-1:0] aAddr,
    input  logic [DATA_W-1:0] aWdata,
    input  logic [2:0]        aBit,
    input  logic              bReq,
    input  logic [1:0]        bCmd,
    input  logic [ADDR_W-1:0] bAddr,
    input  logic [DATA_W-1:0] bWdata,
    input  logic [2:0]        bBit,
    output logic              aAck,
    output logic              bAck,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              byteRamEn,
    output logic              byteRamRw,
    output logic [ADDR_W-1:0] byteRamAddr,
    output logic [DATA_W-1:0] byteRamIn,
    input  logic [DATA_W-1:0] byteRamOut
);

    state_e            state_q, state_d;
    cmd_e              cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [2:0]        bit_q, bit_d;
    logic              from_b_q, from_b_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] bit_mask;
    logic              ram_en_raw;

    // Next-state logic; request inputs are only looked at in IDLE.
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        bit_d    = bit_q;
        from_b_d = from_b_q;
        data_d   = data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (aReq || bReq) begin
                    from_b_d = !aReq;
                    cmd_d    = aReq ? cmd_e'(aCmd) : cmd_e'(bCmd);
                    addr_d   = aReq ? aAddr  : bAddr;
                    wdata_d  = aReq ? aWdata : bWdata;
                    bit_d    = aReq ? aBit   : bBit;
                    if ((aReq ? aCmd : bCmd) == CMD_WRITE) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD_ISSUE;
                    end
                end
            end
            ST_RD_ISSUE: state_d = ST_RD_CAP;
            ST_RD_CAP: begin
                data_d  = byteRamOut;
                state_d = (cmd_q == CMD_READ) ? ST_DONE : ST_WR;
            end
            ST_WR:   state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // RAM side; enable is held through RD_CAP so the registered read data is
    // driven (not high-Z) at the capture edge.
    always_comb begin
        ram_en_raw  = 1'b0;
        byteRamRw   = 1'b1;
        byteRamAddr = '0;
        byteRamIn   = '0;
        bit_mask    = DATA_W'(1) << bit_q;
        unique case (state_q)
            ST_RD_ISSUE, ST_RD_CAP: begin
                ram_en_raw  = 1'b1;
                byteRamAddr = addr_q;
            end
            ST_WR: begin
                ram_en_raw  = 1'b1;
                byteRamRw   = 1'b0;
                byteRamAddr = addr_q;
                unique case (cmd_q)
                    CMD_BIT_SET: byteRamIn = data_q | bit_mask;
                    CMD_BIT_CLR: byteRamIn = data_q & ~bit_mask;
                    default:     byteRamIn = wdata_q;
                endcase
            end
            default: ;
        endcase
    end

    // Reset masks the enable immediately so an aborted write never lands.
    assign byteRamEn = ram_en_raw && !reset;

    assign busy  = (state_q != ST_IDLE);
    assign rdata = data_q;
    assign aAck  = (state_q == ST_DONE) && !from_b_q && !reset;
    assign bAck  = (state_q == ST_DONE) &&  from_b_q && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cmd_q    <= CMD_READ;
            addr_q   <= '0;
            wdata_q  <= '0;
            bit_q    <= '0;
            from_b_q <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            bit_q    <= bit_d;
            from_b_q <= from_b_d;
            data_q   <= data_d;
        end
    end

endmodule

// File: doc/byte_ram_ctrl.md
BYTE_RAM_CTRL -- requirements
Module: byte_ram_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, the byte RAM word width (equal to byteRamLen).
REQ-002 SHALL have parameter ADDR_W, default 7, the byte RAM address width (equal to byteRamAddrLen).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports aReq/bReq, input, 1 bit each: requests from port A (pipeline) and port B (peripheral).
REQ-006 SHALL have ports aCmd/bCmd, input, 2 bits each: 0 READ, 1 WRITE, 2 BIT_SET, 3 BIT_CLR.
REQ-007 SHALL have ports aAddr/bAddr, input, ADDR_W each: target address.
REQ-008 SHALL have ports aWdata/bWdata, input, DATA_W each: write data, used by WRITE only.
REQ-009 SHALL have ports aBit/bBit, input, 3 bits each: bit index, used by BIT_SET and BIT_CLR.
REQ-010 SHALL have ports aAck/bAck, output, 1 bit each: one-cycle completion pulse.
REQ-011 SHALL have port rdata, output, DATA_W: the byte read, or the pre-modify byte for BIT_SET/BIT_CLR.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-013 SHALL have ports byteRamEn/byteRamRw, output, 1 bit each: RAM enable, and RAM direction (1 read, 0 write).
REQ-014 SHALL have ports byteRamAddr (ADDR_W) and byteRamIn (DATA_W), output: RAM address and write data.
REQ-015 SHALL have port byteRamOut, input, DATA_W: registered RAM read data, high-Z when the RAM is disabled.

Function
REQ-016 SHALL implement FSM states IDLE, RD_ISSUE, RD_CAP, WR, DONE.
REQ-017 SHALL, in IDLE with any request high, latch cmd/addr/wdata/bit of the winner at the clock edge and leave IDLE.
REQ-018 SHALL give port A fixed priority when aReq and bReq are high in the same IDLE cycle; bReq stays pending.
REQ-019 SHALL route READ as IDLE->RD_ISSUE->RD_CAP->DONE: ack 3 cycles after acceptance.
REQ-020 SHALL route WRITE as IDLE->WR->DONE: ack 2 cycles after acceptance.
REQ-021 SHALL route BIT_SET/BIT_CLR as IDLE->RD_ISSUE->RD_CAP->WR->DONE: ack 4 cycles after acceptance.
REQ-022 SHALL drive byteRamEn=1, byteRamRw=1 and the latched address in RD_ISSUE and RD_CAP, holding Enable through RD_CAP so byteRamOut is never high-Z when sampled.
REQ-023 SHALL capture byteRamOut into the data register at the edge ending RD_CAP.
REQ-024 SHALL drive byteRamEn=1, byteRamRw=0 in WR, with byteRamIn = wdata (WRITE), captured | (1<<bit) (BIT_SET), or captured & ~(1<<bit) (BIT_CLR).
REQ-025 SHALL, outside those states, drive byteRamEn=0, byteRamRw=1, byteRamAddr=0, byteRamIn=0.
REQ-026 SHALL pulse only the winning port's ack for exactly one cycle in DONE, with rdata valid in that same cycle.
REQ-027 SHALL hold rdata stable until the next capture; rdata is undefined-content but stable after a WRITE.
REQ-028 SHALL return DONE->IDLE unconditionally; a requester drops its req in the cycle its ack is high, and a req still high in IDLE is a new request.
REQ-029 SHALL ignore request-input changes while busy; latched fields are the only operands used.
REQ-030 SHALL allow back-to-back requests: minimum gap of one IDLE cycle between ack and the next acceptance.

Reset
REQ-031 SHALL, on reset high at an edge, set state IDLE, aAck=bAck=0, busy=0, rdata=0 and all latched fields to 0.
REQ-032 SHALL force byteRamEn=0 combinationally whenever reset is high, so a reset asserted during WR or RD_* never writes the RAM.
REQ-033 SHALL abort any in-flight operation on reset without issuing an ack.

Structure
REQ-034 SHALL place the command encodings and FSM state encodings in the shared defines file, alongside byteRamLen and byteRamAddrLen.
REQ-035 SHALL be a single module; the arbiter is inline, with no sub-module.

Verification
REQ-036 SHALL cover: A WRITE addr 0x05 data 0xA5 -> RAM writes 0xA5, aAck 2 cycles later; then A READ 0x05 -> rdata=0xA5, aAck 3 cycles after acceptance.
REQ-037 SHALL cover: addr 0x10=0x00; B BIT_SET bit 3 -> rdata=0x00, bAck 4 cycles later; a READ of 0x10 returns 0x08.
REQ-038 SHALL cover: addr 0x10=0xFF; A BIT_CLR bit 7 -> a READ of 0x10 returns 0x7F.
REQ-039 SHALL cover: aReq and bReq raised in the same cycle -> A served first, aAck then bAck, never both in one cycle.
REQ-040 SHALL cover: reset asserted during WR of BIT_SET on addr 0x20=0x00 -> addr 0x20 stays 0x00, no ack, busy=0 next cycle.
REQ-041 SHALL cover: req inputs toggled while busy -> the latched operation completes with its original operands.
